// File: rtl/xsim_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xsim_pkg
// Description : Shared types and constants for the simulation portal request
//               deframer. Holds the message header layout, the deframer
//               state encoding and the header length constants.
// Revision    : 1.0  initial release
// ============================================================================
package xsim_pkg;

  // Header word: [31:16] method id, [15:0] length in words including header.
  typedef struct packed {
    logic [15:0] method;
    logic [15:0] length;
  } hdr_t;

  typedef enum logic [1:0] {
    ST_HDR        = 2'd0,
    ST_EMIT_EMPTY = 2'd1,
    ST_PAYLOAD    = 2'd2
  } state_t;

  localparam logic [15:0] c_LEN_INVALID  = 16'd0;  // malformed header
  localparam logic [15:0] c_LEN_HDR_ONLY = 16'd1;  // header with no payload
  localparam logic [15:0] c_REM_LAST     = 16'd1;  // remaining count on final beat

endpackage : xsim_pkg
`default_nettype wire

// File: rtl/xsim_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xsim_beat_fifo
// Description : DEPTH x 32 synchronous FIFO buffering the incoming beat
//               stream. Head word is read combinationally so the consumer
//               sees it in the same cycle it decides to pop.
// Ports       : CLK, RST_N    clock, async active-low reset
//               push, wr_data write request and word
//               pop           read request (ignored when empty)
//               full, empty   occupancy flags
//               head          word at the read pointer
// Revision    : 1.0  initial release
// ============================================================================
module xsim_beat_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        push,
  input  logic [31:0] wr_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [31:0] head
);

  localparam int c_AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          w_pop_ok;
  logic          w_push_ok;

  // Extra MSB distinguishes full (wrapped once more) from empty.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                 (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

  assign w_pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign w_push_ok = push && (!full || w_pop_ok);

  assign head = r_mem[r_rd_ptr[c_AW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule : xsim_beat_fifo
`default_nettype wire

// File: rtl/xsim_msg_deframer.sv
`default_nettype none
// ============================================================================
// Module      : xsim_msg_deframer
// Description : Receives the no-backpressure beat stream from the beat sink,
//               buffers it, strips message headers and presents payload
//               beats tagged with the method id on a valid/ready interface.
// Ports       : CLK, RST_N            clock, async active-low reset
//               portal                constant PORTAL_ID
//               src_rdy, beat         incoming beat stream
//               msg_valid, msg_ready  output handshake
//               msg_method, msg_data  method id and payload word
//               msg_last, msg_empty   final beat / no-payload message
//               overflow, hdr_err     sticky error flags
//               msg_count, drop_count statistics (XSIM_DEFRAMER_STATS_EN)
// Options     : `define XSIM_DEFRAMER_STATS_EN to add the statistics counters.
// Revision    : 1.0  initial release
// ============================================================================
module xsim_msg_deframer #(
  parameter int DEPTH     = 16,
  parameter int PORTAL_ID = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  output logic [31:0] portal,
  input  logic        src_rdy,
  input  logic [31:0] beat,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [15:0] msg_method,
  output logic [31:0] msg_data,
  output logic        msg_last,
  output logic        msg_empty,
  output logic        overflow,
  output logic        hdr_err
`ifdef XSIM_DEFRAMER_STATS_EN
  ,
  output logic [31:0] msg_count,
  output logic [31:0] drop_count
`endif
);

  import xsim_pkg::*;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_method;
  logic [15:0] r_remaining;
  logic        r_overflow;
  logic        r_hdr_err;

  logic        w_full;
  logic        w_empty;
  logic [31:0] w_head;
  hdr_t        w_hdr;
  logic        w_pop;
  logic        w_latch;
  logic        w_dec;
  logic        w_hdr_err_set;
  logic        w_drop;

  assign portal     = 32'(PORTAL_ID);
  assign msg_method = r_method;
  assign overflow   = r_overflow;
  assign hdr_err    = r_hdr_err;
  assign w_hdr      = hdr_t'(w_head);
  // A beat is lost only when the buffer is full and nothing leaves this cycle.
  assign w_drop     = src_rdy && w_full && !w_pop;

  xsim_beat_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .push    (src_rdy),
    .wr_data (beat),
    .pop     (w_pop),
    .full    (w_full),
    .empty   (w_empty),
    .head    (w_head)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pop         = 1'b0;
    w_latch       = 1'b0;
    w_dec         = 1'b0;
    w_hdr_err_set = 1'b0;
    msg_valid     = 1'b0;
    msg_last      = 1'b0;
    msg_empty     = 1'b0;
    msg_data      = 32'd0;
    case (r_state)
      ST_HDR: begin
        // Header is consumed internally and never reaches msg_data.
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_hdr.length == c_LEN_INVALID) begin
            w_hdr_err_set = 1'b1;
          end else if (w_hdr.length == c_LEN_HDR_ONLY) begin
            w_latch     = 1'b1;
            w_state_nxt = ST_EMIT_EMPTY;
          end else begin
            w_latch     = 1'b1;
            w_state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_EMIT_EMPTY: begin
        msg_valid = 1'b1;
        msg_empty = 1'b1;
        msg_last  = 1'b1;
        if (msg_ready) w_state_nxt = ST_HDR;
      end
      ST_PAYLOAD: begin
        msg_valid = !w_empty;
        msg_data  = w_empty ? 32'd0 : w_head;
        msg_last  = !w_empty && (r_remaining == c_REM_LAST);
        if (!w_empty && msg_ready) begin
          w_pop = 1'b1;
          w_dec = 1'b1;
          if (r_remaining == c_REM_LAST) w_state_nxt = ST_HDR;
        end
      end
      default: w_state_nxt = ST_HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_method    <= 16'd0;
      r_remaining <= 16'd0;
      r_overflow  <= 1'b0;
      r_hdr_err   <= 1'b0;
    end else begin
      if (w_latch) begin
        r_method    <= w_hdr.method;
        r_remaining <= w_hdr.length - 16'd1;
      end else if (w_dec) begin
        r_remaining <= r_remaining - 16'd1;
      end
      if (w_drop)        r_overflow <= 1'b1;
      if (w_hdr_err_set) r_hdr_err  <= 1'b1;
    end
  end

`ifdef XSIM_DEFRAMER_STATS_EN
  logic        w_accept_last;
  logic [31:0] r_msg_count;
  logic [31:0] r_drop_count;

  assign w_accept_last = msg_valid && msg_ready && msg_last;
  assign msg_count     = r_msg_count;
  assign drop_count    = r_drop_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_msg_count  <= 32'd0;
      r_drop_count <= 32'd0;
    end else begin
      if (w_accept_last) r_msg_count  <= r_msg_count + 32'd1;
      if (w_drop)        r_drop_count <= r_drop_count + 32'd1;
    end
  end
`endif

endmodule : xsim_msg_deframer
`default_nettype wire
